// File: rtl/rmii_pkg.sv
// Shared constants and state encoding for the RMII receive-path frame dispatcher.
package rmii_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR    = 3'd1,
      ST_DECIDE = 3'd2,
      ST_REPLAY = 3'd3,
      ST_BODY   = 3'd4,
      ST_DROP   = 3'd5
   } state_e;

   localparam int          ETH_HDR_LEN = 14;
   localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;
   localparam logic [15:0] ETYPE_ARP   = 16'h0806;
   localparam logic [15:0] ETYPE_IPV4  = 16'h0800;

endpackage

// File: rtl/rmii_rx_dispatch.sv
// Drains the RMII byte FIFO frame by frame, filters on destination MAC and
// forwards each accepted frame to one of two byte-stream consumers by EtherType.
module rmii_rx_dispatch
   import rmii_pkg::*;
#(
   parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETYPE0   = ETYPE_ARP,
   parameter logic [15:0] ETYPE1   = ETYPE_IPV4
) (
   input  logic        REF_CLK,
   input  logic        rst,
   input  logic        cfg_en,
   input  logic        cfg_promisc,
   input  logic [7:0]  fifo_dout,
   input  logic        fifo_EOD_out,
   input  logic        fifo_empty,
   output logic        fifo_rden,
   output logic [7:0]  m_data,
   output logic        m_last,
   output logic [1:0]  m_valid,
   input  logic [1:0]  m_ready,
   output logic [15:0] fwd0_count,
   output logic [15:0] fwd1_count,
   output logic [15:0] drop_count,
   output logic        busy
);

   state_e      state_q, state_d;
   logic        inflight_q;
   logic [3:0]  idx_q, idx_d;
   logic        port_q, port_d;
   logic [7:0]  mdata_q, mdata_d;
   logic        mlast_q, mlast_d;
   logic [1:0]  mvalid_q, mvalid_d;
   logic [15:0] fwd0_q, fwd0_d, fwd1_q, fwd1_d, drop_q, drop_d;
   logic [7:0]  hdr_q [ETH_HDR_LEN];

   logic        hdr_we, rden, accept, addr_ok;
   logic [47:0] dst;
   logic [15:0] etype;
   logic [7:0]  replay_byte;
   logic [1:0]  sel_valid;

   assign accept      = mvalid_q[port_q] & m_ready[port_q];
   assign dst         = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};
   assign etype       = {hdr_q[12], hdr_q[13]};
   assign addr_ok     = cfg_promisc | (dst == MAC_ADDR) | (dst == BCAST_MAC);
   assign replay_byte = (idx_q < 4'(ETH_HDR_LEN)) ? hdr_q[idx_q] : 8'h00;
   assign sel_valid   = port_q ? 2'b10 : 2'b01;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      port_d   = port_q;
      mdata_d  = mdata_q;
      mlast_d  = mlast_q;
      mvalid_d = mvalid_q;
      fwd0_d   = fwd0_q;
      fwd1_d   = fwd1_q;
      drop_d   = drop_q;
      hdr_we   = 1'b0;
      rden     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_en && !fifo_empty) begin
               state_d = ST_HDR;
               idx_d   = '0;
            end
         end
         ST_HDR: begin
            rden = !inflight_q && !fifo_empty;
            if (inflight_q) begin
               hdr_we = 1'b1;
               // EOD anywhere in the header (including byte 13) means nothing to forward
               if (fifo_EOD_out) begin
                  drop_d  = drop_q + 16'd1;
                  state_d = ST_IDLE;
               end else if (idx_q == 4'(ETH_HDR_LEN - 1)) begin
                  state_d = ST_DECIDE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         ST_DECIDE: begin
            idx_d = '0;
            if (addr_ok && etype == ETYPE0) begin
               port_d  = 1'b0;
               state_d = ST_REPLAY;
            end else if (addr_ok && etype == ETYPE1) begin
               port_d  = 1'b1;
               state_d = ST_REPLAY;
            end else begin
               state_d = ST_DROP;
            end
         end
         ST_REPLAY: begin
            // idx_q counts header bytes already loaded into the output register
            if (accept && idx_q == 4'(ETH_HDR_LEN)) begin
               mvalid_d = 2'b00;
               state_d  = ST_BODY;
            end else if ((!mvalid_q[port_q] || accept) && idx_q < 4'(ETH_HDR_LEN)) begin
               mdata_d  = replay_byte;
               mlast_d  = 1'b0;
               mvalid_d = sel_valid;
               idx_d    = idx_q + 4'd1;
            end
         end
         ST_BODY: begin
            rden = !inflight_q && !fifo_empty && (!mvalid_q[port_q] || (accept && !mlast_q));
            if (accept) begin
               mvalid_d = 2'b00;
               if (mlast_q) begin
                  if (port_q) fwd1_d = fwd1_q + 16'd1;
                  else        fwd0_d = fwd0_q + 16'd1;
                  state_d = ST_IDLE;
               end
            end
            // a read is only issued once the holding register is free, so this never collides
            if (inflight_q) begin
               mdata_d  = fifo_dout;
               mlast_d  = fifo_EOD_out;
               mvalid_d = sel_valid;
            end
         end
         ST_DROP: begin
            rden = !inflight_q && !fifo_empty;
            if (inflight_q && fifo_EOD_out) begin
               drop_d  = drop_q + 16'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign fifo_rden = rden & ~rst;

   always_ff @(posedge REF_CLK) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         inflight_q <= 1'b0;
         idx_q      <= '0;
         port_q     <= 1'b0;
         mdata_q    <= '0;
         mlast_q    <= 1'b0;
         mvalid_q   <= '0;
         fwd0_q     <= '0;
         fwd1_q     <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= fifo_rden;
         idx_q      <= idx_d;
         port_q     <= port_d;
         mdata_q    <= mdata_d;
         mlast_q    <= mlast_d;
         mvalid_q   <= mvalid_d;
         fwd0_q     <= fwd0_d;
         fwd1_q     <= fwd1_d;
         drop_q     <= drop_d;
      end
   end

   always_ff @(posedge REF_CLK) begin
      if (hdr_we) hdr_q[idx_q] <= fifo_dout;
   end

   assign m_data     = mdata_q;
   assign m_last     = mlast_q;
   assign m_valid    = mvalid_q;
   assign fwd0_count = fwd0_q;
   assign fwd1_count = fwd1_q;
   assign drop_count = drop_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rmii_rx_dispatch.sv
// Self-checking bench for rmii_rx_dispatch: FIFO model, per-port scoreboard,
// table-driven frames, hand-written corner sequences and randomized batches.
module tb_rmii_rx_dispatch;

   localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;

   logic        REF_CLK = 1'b0;
   logic        rst = 1'b1, cfg_en = 1'b0, cfg_promisc = 1'b0;
   logic [7:0]  fifo_dout;
   logic        fifo_EOD_out;
   logic        fifo_empty, fifo_rden;
   logic [7:0]  m_data;
   logic        m_last;
   logic [1:0]  m_valid;
   logic [1:0]  m_ready = 2'b11;
   logic [15:0] fwd0_count, fwd1_count, drop_count;
   logic        busy;

   rmii_rx_dispatch dut (
      .REF_CLK(REF_CLK), .rst(rst), .cfg_en(cfg_en), .cfg_promisc(cfg_promisc),
      .fifo_dout(fifo_dout), .fifo_EOD_out(fifo_EOD_out), .fifo_empty(fifo_empty),
      .fifo_rden(fifo_rden), .m_data(m_data), .m_last(m_last), .m_valid(m_valid),
      .m_ready(m_ready), .fwd0_count(fwd0_count), .fwd1_count(fwd1_count),
      .drop_count(drop_count), .busy(busy)
   );

   always #10 REF_CLK = ~REF_CLK;

   // FIFO model: read data appears the cycle after fifo_rden, emptied by reset
   logic [8:0] mem [0:4095];
   int wr_ptr = 0, rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge REF_CLK) begin
      if (rst) begin
         rd_ptr       <= wr_ptr;
         fifo_dout    <= 8'h00;
         fifo_EOD_out <= 1'b0;
      end else if (fifo_rden) begin
         {fifo_EOD_out, fifo_dout} <= mem[rd_ptr % 4096];
         rd_ptr <= rd_ptr + 1;
      end
   end

   int nchk = 0, nerr = 0, cyc = 0, mode = 0;
   int rx0 = 0, rx1 = 0, e_fwd0 = 0, e_fwd1 = 0, e_drop = 0;
   bit tog = 1'b0;
   logic [8:0] q0[$], q1[$];
   logic [1:0] prev_v = 2'b00, prev_r = 2'b00;
   logic [7:0] prev_d = 8'h00;
   logic       prev_l = 1'b0;
   logic [7:0] fr [0:255];
   int frlen = 0;

   typedef struct {
      logic [47:0] dst;
      logic [15:0] et;
      int          len;
      bit          pr;
      int          rmode;
      int          exp_port;   // 0/1 forwarded to that port, 2 dropped
   } vec_t;
   vec_t tv [10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic take(input int p);
      logic [8:0] e;
      if (p == 0) begin
         chk("p0 byte pending", 64'(q0.size() > 0), 64'd1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("p0 byte", 64'({m_last, m_data}), 64'(e));
         end
         rx0++;
      end else begin
         chk("p1 byte pending", 64'(q1.size() > 0), 64'd1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("p1 byte", 64'({m_last, m_data}), 64'(e));
         end
         rx1++;
      end
   endtask

   // One cycle: drive m_ready, then check handshakes that complete at the next posedge
   task automatic tick();
      @(negedge REF_CLK);
      cyc++;
      case (mode)
         0:       m_ready = 2'b11;
         1:       begin tog = ~tog; m_ready = {tog, ~tog}; end
         default: m_ready = 2'($urandom_range(0, 3));
      endcase
      if (rst) begin
         prev_v = 2'b00;
      end else begin
         if (m_valid != 2'b00) chk("valid onehot", 64'($countones(m_valid)), 64'd1);
         if ((prev_v & ~prev_r) != 2'b00)
            chk("stall hold", 64'({m_valid, m_last, m_data}), 64'({prev_v, prev_l, prev_d}));
         if (m_valid[0] && m_ready[0]) take(0);
         if (m_valid[1] && m_ready[1]) take(1);
         prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_l = m_last;
      end
   endtask

   function automatic int model(logic [47:0] d, logic [15:0] et, int len, bit pr);
      bit ok;
      if (len <= 14) return 2;
      ok = pr || d == MAC || d == BCAST;
      if (ok && et == 16'h0806) return 0;
      if (ok && et == 16'h0800) return 1;
      return 2;
   endfunction

   task automatic build(input logic [47:0] d, input logic [15:0] et, input int len);
      frlen = len;
      for (int i = 0; i < 256; i++) begin
         if (i < 6)        fr[i] = 8'(d >> (8 * (5 - i)));
         else if (i < 12)  fr[i] = 8'($urandom);
         else if (i == 12) fr[i] = et[15:8];
         else if (i == 13) fr[i] = et[7:0];
         else              fr[i] = 8'($urandom);
      end
   endtask

   task automatic push_frame(input int port);
      logic [8:0] w;
      for (int i = 0; i < frlen; i++) begin
         w = {(i == frlen - 1), fr[i]};
         mem[wr_ptr % 4096] = w;
         wr_ptr++;
         if (port == 0) q0.push_back(w);
         else if (port == 1) q1.push_back(w);
      end
      if (port == 0) e_fwd0++;
      else if (port == 1) e_fwd1++;
      else e_drop++;
   endtask

   task automatic drain(input string nm, input int max);
      bit ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (rd_ptr == wr_ptr && !busy && m_valid == 2'b00) begin ok = 1'b1; break; end
      end
      chk({nm, " drained"}, 64'(ok), 64'd1);
   endtask

   task automatic verify(input string nm);
      chk({nm, " fwd0_count"}, 64'(fwd0_count), 64'(16'(e_fwd0)));
      chk({nm, " fwd1_count"}, 64'(fwd1_count), 64'(16'(e_fwd1)));
      chk({nm, " drop_count"}, 64'(drop_count), 64'(16'(e_drop)));
      chk({nm, " p0 undelivered"}, 64'(q0.size()), 64'd0);
      chk({nm, " p1 undelivered"}, 64'(q1.size()), 64'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, port, start;
      bit hit;
      logic [47:0] d;
      logic [15:0] et;

      tv[0] = '{MAC,   16'h0806, 64, 1'b0, 0, 0};
      tv[1] = '{BCAST, 16'h0800, 70, 1'b0, 1, 1};
      tv[2] = '{OTHER, 16'h0800, 60, 1'b0, 2, 2};
      tv[3] = '{OTHER, 16'h0800, 60, 1'b1, 2, 1};
      tv[4] = '{MAC,   16'h86DD, 50, 1'b0, 0, 2};
      tv[5] = '{MAC,   16'h0806, 14, 1'b0, 0, 2};
      tv[6] = '{MAC,   16'h0806, 15, 1'b0, 1, 0};
      tv[7] = '{MAC,   16'h0806,  1, 1'b0, 0, 2};
      tv[8] = '{OTHER, 16'h0806, 60, 1'b1, 2, 0};
      tv[9] = '{BCAST, 16'h0806, 40, 1'b1, 2, 0};

      // reset values
      repeat (3) tick();
      chk("reset m_valid", 64'(m_valid), 64'd0);
      chk("reset m_data", 64'(m_data), 64'd0);
      chk("reset m_last", 64'(m_last), 64'd0);
      chk("reset fifo_rden", 64'(fifo_rden), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset counters", 64'({fwd0_count, fwd1_count, drop_count}), 64'd0);
      rst = 1'b0;
      cfg_en = 1'b1;
      tick();

      // first-byte latency on a 64-byte ARP frame
      build(MAC, 16'h0806, 64);
      push_frame(0);
      c0 = 0; c1 = 0; hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin tick(); if (fifo_rden) begin hit = 1'b1; c0 = cyc; end end
      chk("first rden seen", 64'(hit), 64'd1);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin tick(); if (m_valid != 2'b00) begin hit = 1'b1; c1 = cyc; end end
      chk("first m_valid seen", 64'(hit), 64'd1);
      chk("rden to m_valid cycles", 64'(c1 - c0), 64'd30);
      drain("latency", 2000);
      verify("latency");

      // table-driven frames
      foreach (tv[i]) begin
         mode = tv[i].rmode;
         cfg_promisc = tv[i].pr;
         build(tv[i].dst, tv[i].et, tv[i].len);
         push_frame(tv[i].exp_port);
         drain($sformatf("vec%0d", i), 3000);
         verify($sformatf("vec%0d", i));
      end
      cfg_promisc = 1'b0;
      mode = 0;

      // runt immediately followed by a good frame
      build(MAC, 16'h0806, 10);
      push_frame(2);
      build(BCAST, 16'h0800, 40);
      push_frame(1);
      drain("runt+frame", 3000);
      verify("runt+frame");

      // cfg_en dropped mid-frame: current frame completes, next one waits
      build(MAC, 16'h0806, 80);
      push_frame(0);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin tick(); hit = busy; end
      chk("cfg_en frame started", 64'(hit), 64'd1);
      cfg_en = 1'b0;
      build(BCAST, 16'h0800, 30);
      push_frame(1);
      hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin tick(); hit = (fwd0_count == 16'(e_fwd0)); end
      chk("cfg_en current frame done", 64'(hit), 64'd1);
      repeat (100) tick();
      chk("cfg_en idle while disabled", 64'(busy), 64'd0);
      chk("cfg_en next frame untouched", 64'(wr_ptr - rd_ptr), 64'd30);
      cfg_en = 1'b1;
      drain("cfg_en", 3000);
      verify("cfg_en");

      // randomized batches of back-to-back frames against the reference model
      for (int b = 0; b < 10; b++) begin
         cfg_promisc = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 2);
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 3))
               0:       d = MAC;
               1:       d = BCAST;
               2:       d = OTHER;
               default: d = 48'({$urandom(), $urandom()});
            endcase
            case ($urandom_range(0, 3))
               0:       et = 16'h0806;
               1:       et = 16'h0800;
               2:       et = 16'h86DD;
               default: et = 16'($urandom);
            endcase
            build(d, et, $urandom_range(1, 90));
            port = model(d, et, frlen, cfg_promisc);
            push_frame(port);
         end
         drain($sformatf("rand%0d", b), 20000);
         verify($sformatf("rand%0d", b));
      end
      cfg_promisc = 1'b0;
      mode = 0;

      // reset asserted mid-BODY
      build(BCAST, 16'h0800, 200);
      push_frame(1);
      start = rx1;
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin tick(); hit = (rx1 >= start + 30); end
      chk("reset test reached body", 64'(hit), 64'd1);
      rst = 1'b1;
      tick();
      chk("midreset m_valid", 64'(m_valid), 64'd0);
      chk("midreset m_data", 64'(m_data), 64'd0);
      chk("midreset m_last", 64'(m_last), 64'd0);
      chk("midreset fifo_rden", 64'(fifo_rden), 64'd0);
      chk("midreset busy", 64'(busy), 64'd0);
      chk("midreset counters", 64'({fwd0_count, fwd1_count, drop_count}), 64'd0);
      rst = 1'b0;
      q0.delete();
      q1.delete();
      e_fwd0 = 0; e_fwd1 = 0; e_drop = 0;
      tick();
      build(MAC, 16'h0806, 20);
      push_frame(0);
      drain("post-reset", 2000);
      verify("post-reset");

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/rmii_rx_dispatch.md
# rmii_rx_dispatch

- Frame-level controller for the receive path.
- Drains the byte FIFO written by the RMII receiver; each byte carries an end-of-data (EOD) flag.
- Captures the 14-byte Ethernet header, filters on destination MAC and dispatches each frame by EtherType to one of two consumers over a valid/ready byte stream.
- Rejected frames are drained and counted.

## Interface

Parameters:
- MAC_ADDR, 48'h02_00_00_00_00_01, station address; byte 0 is the first received byte = bits [47:40]
- ETYPE0, 16'h0806, EtherType routed to port 0 (ARP)
- ETYPE1, 16'h0800, EtherType routed to port 1 (IPv4)

Ports:
- REF_CLK  in  1  single clock, shared with the receiver and FIFO read side
- rst  in  1  reset; synchronous, active-high
- cfg_en  in  1  when high, new frames may start
- cfg_promisc  in  1  when high, MAC filter is bypassed
- fifo_dout  in  8  FIFO read data, valid the cycle after fifo_rden
- fifo_EOD_out  in  1  EOD flag of fifo_dout
- fifo_empty  in  1  FIFO empty
- fifo_rden  out  1  FIFO read strobe
- m_data  out  8  output byte, shared by both ports
- m_last  out  1  last byte of frame
- m_valid  out  2  per-port valid; at most one bit set
- m_ready  in  2  per-port ready
- fwd0_count, fwd1_count  out  16  frames forwarded per port, binary, wrap
- drop_count  out  16  frames dropped, binary, wrap
- busy  out  1  state is not IDLE

## Operation

- States: IDLE, HDR, DECIDE, REPLAY, BODY, DROP.
- Read rule, all states:
  - At most one FIFO read is in flight.
  - A new fifo_rden is issued only if fifo_empty=0, no read is in flight, and the previous returned byte had EOD=0 or the frame has ended.
  - The block never reads past an EOD byte into the next frame.
- IDLE → HDR when cfg_en=1 and fifo_empty=0. The first read is issued in HDR.
- HDR:
  - Stores returned bytes into a 14-entry header buffer, indexed 0..13.
  - A byte with EOD=1 before index 13 marks a runt: drop_count+1, → IDLE. The frame is already fully consumed.
  - Byte 13 returned with EOD=0 → DECIDE.
  - Byte 13 returned with EOD=1 → drop_count+1, → IDLE.
- DECIDE, one cycle:
  - addr_ok = cfg_promisc, or dst == MAC_ADDR, or dst == 48'hFFFF_FFFF_FFFF.
  - EtherType = {hdr[12], hdr[13]}.
  - addr_ok and EtherType == ETYPE0 → port 0, REPLAY.
  - addr_ok and EtherType == ETYPE1 → port 1, REPLAY.
  - Otherwise → DROP.
- REPLAY:
  - Presents hdr[0..13] on m_data with m_valid[port]=1, m_last=0.
  - Advances one byte per cycle in which m_ready[port]=1.
  - After hdr[13] is accepted → BODY.
- BODY:
  - Each returned FIFO byte goes into a 1-byte output holding register. It is presented with m_last = its EOD flag.
  - The next read is issued only once the holding register has been accepted, or is being accepted this cycle.
  - Accepted byte with m_last=1: fwdN_count+1, → IDLE.
- DROP:
  - Reads until a byte with EOD=1 returns, then drop_count+1, → IDLE.
  - m_valid stays 0.
- cfg_en=0 only blocks IDLE → HDR. A frame in progress completes normally.
- Counters wrap 16'hFFFF → 0. No two counter increments occur in the same cycle.

## Timing

- Reset values: STATE=IDLE, fifo_rden=0, m_valid=0, m_data=0, m_last=0, all counters 0, busy=0.
- The FIFO and receiver share rst, so the FIFO is empty after reset. A reset mid-frame discards all state, with no count.
- fifo_rden → data one cycle later, so HDR takes 28 cycles minimum (one byte per 2 cycles). DECIDE takes 1 cycle.
- Throughput is 25 MB/s at a 50 MHz REF_CLK, above the 12.5 MB/s of 100 Mb/s RMII.
- First output byte: m_valid rises 30 cycles after the first fifo_rden.
- m_data, m_last and m_valid are registered and held stable while m_valid=1 and m_ready=0.
- m_ready is ignored while m_valid=0, and the m_ready bit of the non-selected port is always ignored.

## Structure

- Shared package rmii_pkg holds:
  - state encodings (3-bit);
  - ETH_HDR_LEN=14, BCAST_MAC and default EtherType constants.
- No sub-modules. The header buffer is a 14×8 register array inside the block.
- Counters are binary here. Gray conversion for cross-domain monitoring is done outside with my_bin2gray.

## Test plan

- 64-byte frame, dst=MAC_ADDR, EtherType 0x0806, m_ready=11 → port 0 receives 64 bytes, m_last on byte 64, fwd0_count=1.
- Broadcast frame, EtherType 0x0800, m_ready[1] toggled every other cycle → port 1 receives all bytes in order, data stable while stalled, fwd1_count=1.
- dst=02:00:00:00:00:02, cfg_promisc=0 → nothing output, full frame drained, drop_count=1; the same frame with cfg_promisc=1 is forwarded.
- 10-byte runt (EOD on byte 10) followed immediately by a valid frame → drop_count=1; the second frame is forwarded intact, with no bytes lost or merged.
- EtherType 0x86DD → DROP, drop_count=1. cfg_en dropped mid-frame → current frame completes, next frame not started until cfg_en=1.
- Reset asserted mid-BODY → all outputs and counters 0 the next cycle, state IDLE.
